// File: rtl/bz_player.sv
// Music-ROM driven square-wave buzzer player: fetches 12-bit note words, plays each tone for its duration.
// Optional articulation gap at the end of every note is enabled by defining BZ_GAP_EN.
module bz_player #(
    parameter int ADDR_WIDTH = 11,
    parameter int TICK_DIV   = 50,
    parameter int BEAT_TICKS = 125000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [11:0]           rom_data,
    output logic                  buzzer_o,
    output logic                  busy,
    output logic                  done
);

    localparam int TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LEN_W     = $clog2(63 * BEAT_TICKS + 1);
    localparam int HALF_W    = 11;
    localparam int GAP_TICKS = BEAT_TICKS / 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        DECODE,
        PLAY
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [HALF_W-1:0]   half_reg, half_next;
    logic [LEN_W-1:0]    len_reg, len_next;
    logic                rest_reg, rest_next;
    logic [HALF_W-1:0]   tone_cnt_reg, tone_cnt_next;
    logic [LEN_W-1:0]    dur_cnt_reg, dur_cnt_next;
    logic                buzz_reg, buzz_next;
    logic                done_reg, done_next;
    logic [TICK_W-1:0]   tick_cnt_reg;
    logic                tick;

    // Free-running 1 us tick, independent of playback state
    assign tick = (tick_cnt_reg == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
        end
    end

    function automatic logic [HALF_W-1:0] base_half(input logic [3:0] note);
        case (note)
            4'd1:    base_half = 11'd1911;
            4'd2:    base_half = 11'd1804;
            4'd3:    base_half = 11'd1703;
            4'd4:    base_half = 11'd1607;
            4'd5:    base_half = 11'd1517;
            4'd6:    base_half = 11'd1432;
            4'd7:    base_half = 11'd1351;
            4'd8:    base_half = 11'd1276;
            4'd9:    base_half = 11'd1204;
            4'd10:   base_half = 11'd1136;
            4'd11:   base_half = 11'd1073;
            4'd12:   base_half = 11'd1012;
            default: base_half = 11'd0;
        endcase
    endfunction

    logic [3:0]        dec_note;
    logic [1:0]        dec_oct;
    logic [5:0]        dec_dur;
    logic [HALF_W-1:0] dec_half;
    logic [LEN_W-1:0]  dec_len;
    logic              dec_rest;

    assign dec_note = rom_data[11:8];
    assign dec_oct  = rom_data[7:6];
    assign dec_dur  = (rom_data[5:0] == 6'd0) ? 6'd1 : rom_data[5:0];
    assign dec_half = base_half(dec_note) >> dec_oct;
    assign dec_len  = LEN_W'(dec_dur) * LEN_W'(BEAT_TICKS);
    assign dec_rest = (dec_note == 4'd0) || (dec_note == 4'd13);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            half_reg     <= '0;
            len_reg      <= '0;
            rest_reg     <= 1'b0;
            tone_cnt_reg <= '0;
            dur_cnt_reg  <= '0;
            buzz_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            half_reg     <= half_next;
            len_reg      <= len_next;
            rest_reg     <= rest_next;
            tone_cnt_reg <= tone_cnt_next;
            dur_cnt_reg  <= dur_cnt_next;
            buzz_reg     <= buzz_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        half_next     = half_reg;
        len_next      = len_reg;
        rest_next     = rest_reg;
        tone_cnt_next = tone_cnt_reg;
        dur_cnt_next  = dur_cnt_reg;
        buzz_next     = 1'b0;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    addr_next  = '0;
                    state_next = FETCH;
                end
            end
            FETCH: state_next = WAIT;
            WAIT:  state_next = DECODE;
            DECODE: begin
                half_next     = dec_half;
                len_next      = dec_len;
                rest_next     = dec_rest;
                tone_cnt_next = '0;
                dur_cnt_next  = '0;
                if (dec_note == 4'd15) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (dec_note == 4'd14) begin
                    addr_next  = '0;
                    state_next = FETCH;
                end else begin
                    state_next = PLAY;
                end
            end
            PLAY: begin
                buzz_next = buzz_reg;
                if (tick) begin
                    if (dur_cnt_reg == len_reg - LEN_W'(1)) begin
                        buzz_next  = 1'b0;
                        addr_next  = addr_reg + ADDR_WIDTH'(1);
                        state_next = FETCH;
                    end else begin
                        dur_cnt_next = dur_cnt_reg + LEN_W'(1);
                        if (tone_cnt_reg == half_reg - HALF_W'(1)) begin
                            tone_cnt_next = '0;
                            buzz_next     = ~buzz_reg & ~rest_reg;
                        end else begin
                            tone_cnt_next = tone_cnt_reg + HALF_W'(1);
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort wins over everything except reset, and never reports completion
        if (stop) begin
            state_next = IDLE;
            buzz_next  = 1'b0;
            done_next  = 1'b0;
        end
    end

    assign rom_en   = (state_reg == FETCH);
    assign rom_addr = addr_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;

`ifdef BZ_GAP_EN
    // Silence the tail of each note; the tone counter keeps its phase underneath
    logic gap;
    assign gap      = (state_reg == PLAY) && (dur_cnt_reg >= len_reg - LEN_W'(GAP_TICKS));
    assign buzzer_o = buzz_reg & ~gap;
`else
    assign buzzer_o = buzz_reg;
`endif

endmodule

// File: tb/tb_bz_player.sv
// Directed bench for bz_player with a 4-word synchronous ROM model; TICK_DIV=1, BEAT_TICKS=3000.
module tb_bz_player;

    localparam int AW = 2;
`ifdef BZ_GAP_EN
    localparam int DROP_C = 2628;
`else
    localparam int DROP_C = 3003;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [11:0]   rom_data;
    logic          buzzer_o;
    logic          busy;
    logic          done;

    logic [11:0] rom [4];

    int total = 0;
    int bad   = 0;

    bz_player #(
        .ADDR_WIDTH(AW),
        .TICK_DIV  (1),
        .BEAT_TICKS(3000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .rom_en  (rom_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .buzzer_o(buzzer_o),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    // Event log sampled on the falling edge
    int   cyc = 0;
    int   done_cnt = 0;
    logic buz_prev = 1'b0;
    int   en_addr[$];
    int   en_cyc[$];
    int   chg[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rom_en === 1'b1) begin
            en_addr.push_back(int'(rom_addr));
            en_cyc.push_back(cyc);
        end
        if (buzzer_o !== buz_prev) chg.push_back(cyc);
        buz_prev <= buzzer_o;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
    endtask

    task automatic wait_en(input int target, input int budget, input string tag);
        int n = 0;
        while (en_addr.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(en_addr.size() >= target), 32'd1);
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        int n = 0;
        while (done_cnt <= d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done_cnt > d0), 32'd1);
    endtask

    int ea, ch, d0, c0;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 4; i++) rom[i] = 12'hF00;

        // Reset state and idle behaviour
        repeat (3) @(negedge clk);
        chk("rst_buzzer", 32'(buzzer_o), 32'd0);
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_no_fetch", 32'(en_addr.size()), 32'd0);

        // A (note 10, octave 0, 2 beats) then end
        rom[0] = 12'hA02;
        rom[1] = 12'hF00;
        @(posedge clk);
        ea = en_addr.size(); ch = chg.size(); d0 = done_cnt;
        pulse_start();
        chk("a_first_en", 32'(rom_en), 32'd1);
        chk("a_first_addr", 32'(rom_addr), 32'd0);
        chk("a_busy", 32'(busy), 32'd1);
        wait_done(d0, 10000, "a_done_timeout");
        repeat (2) @(negedge clk);
        c0 = en_cyc[ea];
        chk("a_busy_fall", 32'(busy), 32'd0);
        chk("a_done_once", 32'(done_cnt - d0), 32'd1);
        chk("a_fetches", 32'(en_addr.size() - ea), 32'd2);
        chk("a_second_addr", 32'(en_addr[ea+1]), 32'd1);
        chk("a_note_cycles", 32'(en_cyc[ea+1] - c0), 32'd6003);
        chk("a_edges", 32'(chg.size() - ch), 32'd6);
        chk("a_first_toggle", 32'(chg[ch] - c0), 32'd1139);
        chk("a_four_halves", 32'(chg[ch+4] - chg[ch]), 32'd4544);
        chk("a_end_low", 32'(chg[ch+5] - c0), 32'd6003);

        // A one octave up twice: half-period 284
        rom[0] = 12'hA81;
        @(posedge clk);
        ea = en_addr.size(); ch = chg.size(); d0 = done_cnt;
        pulse_start();
        wait_done(d0, 10000, "b_done_timeout");
        repeat (2) @(negedge clk);
        c0 = en_cyc[ea];
        chk("b_edges", 32'(chg.size() - ch), 32'd10);
        chk("b_first_toggle", 32'(chg[ch] - c0), 32'd287);
        chk("b_half", 32'(chg[ch+1] - chg[ch]), 32'd284);

        // Rest: silent for the whole note
        rom[0] = 12'h001;
        @(posedge clk);
        ea = en_addr.size(); ch = chg.size(); d0 = done_cnt;
        pulse_start();
        wait_done(d0, 10000, "c_done_timeout");
        repeat (2) @(negedge clk);
        chk("c_silent", 32'(chg.size() - ch), 32'd0);
        chk("c_fetches", 32'(en_addr.size() - ea), 32'd2);

        // Loop code returns to address 0, then stop mid-note
        rom[0] = 12'hA01;
        rom[1] = 12'hE00;
        @(posedge clk);
        ea = en_addr.size(); d0 = done_cnt;
        pulse_start();
        wait_en(ea + 3, 10000, "d_loop_timeout");
        chk("d_addr1", 32'(en_addr[ea+1]), 32'd1);
        chk("d_loop_addr", 32'(en_addr[ea+2]), 32'd0);
        chk("d_loop_gap", 32'(en_cyc[ea+2] - en_cyc[ea+1]), 32'd3);
        chk("d_no_done", 32'(done_cnt - d0), 32'd0);
        repeat (1500) @(negedge clk);
        chk("d_buzz_high", 32'(buzzer_o), 32'd1);
        pulse_stop();
        chk("d_stop_busy", 32'(busy), 32'd0);
        chk("d_stop_buzz", 32'(buzzer_o), 32'd0);
        chk("d_stop_en", 32'(rom_en), 32'd0);
        repeat (10) @(negedge clk);
        chk("d_stop_no_done", 32'(done_cnt - d0), 32'd0);
        chk("d_stop_quiet", 32'(en_addr.size() - ea), 32'd3);

        // Simultaneous start and stop
        ea = en_addr.size();
        @(negedge clk) begin start = 1'b1; stop = 1'b1; end
        @(negedge clk) begin start = 1'b0; stop = 1'b0; end
        chk("ss_busy", 32'(busy), 32'd0);
        chk("ss_en", 32'(rom_en), 32'd0);
        repeat (10) @(negedge clk);
        chk("ss_no_fetch", 32'(en_addr.size() - ea), 32'd0);

        // Address wrap on a 4-word ROM; extra start while busy must be ignored
        for (int i = 0; i < 4; i++) rom[i] = 12'h101;
        @(posedge clk);
        ea = en_addr.size(); ch = chg.size();
        pulse_start();
        repeat (1000) @(negedge clk);
        pulse_start();
        chk("e_busy", 32'(busy), 32'd1);
        wait_en(ea + 5, 20000, "e_wrap_timeout");
        c0 = en_cyc[ea];
        chk("e_addr_seq", 32'({en_addr[ea][3:0], en_addr[ea+1][3:0], en_addr[ea+2][3:0],
                                en_addr[ea+3][3:0], en_addr[ea+4][3:0]}), 32'h01230);
        chk("e_first_toggle", 32'(chg[ch] - c0), 32'd1914);
        chk("e_note_tail", 32'(chg[ch+1] - c0), 32'(DROP_C));
        pulse_stop();

        // Reset mid-note overrides a concurrent start
        pulse_start();
        repeat (200) @(negedge clk);
        @(negedge clk) begin rst = 1'b1; start = 1'b1; end
        @(negedge clk) begin rst = 1'b0; start = 1'b0; end
        chk("f_rst_busy", 32'(busy), 32'd0);
        chk("f_rst_buzz", 32'(buzzer_o), 32'd0);
        chk("f_rst_addr", 32'(rom_addr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
